voice_sine_mixer: RTL and testbench
===================================

Name: voice_sine_mixer

Overview:
- Consumes the 8 per-voice 32-bit phase words from the phase accumulator and converts each to a sine sample.
- Uses one time-multiplexed sine ROM lookup per voice and sums the gated voices into a single signed mixed sample, once per audio sample tick.
- Sits between the phase accumulator and the audio output stage (PWM/DAC path).
- Produces one valid-pulsed mix per tick.

Parameters:
- N_VOICES, 8: number of voices; fixed by the phase accumulator interface.
- ADDR_W, 8: ROM index width; index = phase[31 -: ADDR_W].
- SAMPLE_W, 8: signed ROM sample width.
- ROM_LAT, 2: sine ROM read latency in cycles (registered address plus registered data).

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: asynchronous, active-high reset.
- sample_tick_in, input, 1: one-cycle pulse at the audio sample rate; starts one mix pass.
- gate_in, input, 8: per-voice active flags; same encoding as the accumulator gate.
- phase_in, input, 32 x 8 (unpacked [7:0]): per-voice phase words.
- mix_out, output, SAMPLE_W+3 (11), signed: sum of active voice samples.
- mix_valid_out, output, 1: one-cycle pulse when mix_out is updated.
- active_cnt_out, output, 4: number of gated voices in the latched snapshot.
- busy_out, output, 1: high while a pass is in progress.
- overrun_out, output, 1: one-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset (async, any time, including mid-pass):
  - mix_out=0, mix_valid_out=0, active_cnt_out=0, busy_out=0, overrun_out=0.
  - State returns to IDLE; accumulator, snapshot and pipeline valid bits are cleared.
- States are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - On the edge sampling sample_tick_in=1, snapshot all 8 phase_in words and gate_in into internal registers.
  - Clear the accumulator, set voice index to 0 and go to ISSUE. busy_out goes high from the next cycle.
- ISSUE:
  - Present ROM index = snap_phase[idx][31:24] for idx = 0..7, one per cycle, each with a tagged valid bit carrying snap_gate[idx].
  - After idx=7, go to DRAIN.
- DRAIN:
  - Wait ROM_LAT cycles for the last data to emerge.
  - Each returning ROM word is sign-extended to 11 bits and added to the accumulator if its tag gate=1, otherwise it adds 0.
  - After the last return, go to DONE.
- DONE:
  - Register mix_out = accumulator and active_cnt_out = popcount(snap_gate).
  - Pulse mix_valid_out for exactly one cycle, then return to IDLE. busy_out deasserts in the cycle after DONE.
- Latency: mix_valid_out asserts exactly N_VOICES+ROM_LAT+2 = 12 cycles after the edge sampling the tick.
  - The next tick is accepted at 13 cycles or more.
- Outputs hold their values between passes. mix_out changes only together with mix_valid_out.
- Tick while busy (any state other than IDLE):
  - The tick is ignored and the pass in progress is unaffected.
  - overrun_out pulses for one cycle.
- A tick in the same cycle as DONE→IDLE is also an overrun (IDLE is not yet registered).
- Changes on phase_in/gate_in during a pass have no effect; only the snapshot is used.
- Arithmetic:
  - The 8 signed 8-bit values lie in [-127, 127], so the sum lies in [-1016, 1016] and fits 11 bits signed. No saturation is needed.
  - Phase wrap is inherent (modulo 2^32); index 255 is followed by 0.
- ROM contents: rom[i] = round(127*sin(2*pi*i/256)).
  - rom[0]=0, rom[64]=127, rom[128]=0, rom[192]=-127.
  - Range is symmetric; -128 never appears.

Decomposition:
- Shared package synth_pkg holds:
  - N_VOICES, PHASE_W=32, SAMPLE_W, ADDR_W;
  - the mixer state enum (IDLE, ISSUE, DRAIN, DONE);
  - the phase_t / sample_t typedefs.
- The phase accumulator also uses phase_t and N_VOICES from this package.
- One sub-module, sine_rom: 256 x 8 signed, registered address and data (ROM_LAT=2).
  - Contents are generated at elaboration or from a .mem file; both must give identical values.

Test Plan:
- All voices, phase 0:
  - Stimulus: gate=8'hFF, all phase_in=32'h0000_0000, one tick.
  - Required: mix_out=0, active_cnt_out=8, mix_valid_out pulses exactly 12 cycles after the tick.
- Quarter and three-quarter phase:
  - Stimulus: gate=8'h03, phase[0]=32'h4000_0000, phase[1]=32'h4000_0000, others arbitrary.
  - Required: mix_out=254, active_cnt_out=2. Repeat with phase=32'hC000_0000 → mix_out=-254.
- Extremes and gating:
  - Stimulus: gate=8'hFF, all phase=32'h4000_0000 → mix_out=1016; all phase=32'hC0FF_FFFF → mix_out=-1016.
  - Stimulus: gate=8'h00, any phases → mix_out=0, active_cnt_out=0.
- Snapshot and overrun:
  - Stimulus: change phase_in/gate_in at cycle 3 of a pass, and issue a second tick at cycle 5.
  - Required: the result reflects the original snapshot, overrun_out pulses once, no second mix_valid_out for that tick.
  - A tick at cycle 13 starts a new pass normally.
- Reset mid-pass:
  - Stimulus: assert rst_in asynchronously at cycle 6 of a pass.
  - Required: all outputs are 0 immediately, no mix_valid_out follows, and a tick after release produces a correct 12-cycle pass.
- Random regression:
  - Stimulus: 1000 ticks spaced at 16 or more cycles, with random gate/phase.
  - Required: mix_out matches a reference model (sum of rom[phase>>24] over gated voices).

Source files
------------

// File: rtl/synth_pkg.sv
// Shared voice-synth types, sizes, ROM contents and small helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package synth_pkg;

    localparam int N_VOICES = 8;
    localparam int PHASE_W  = 32;
    localparam int SAMPLE_W = 8;
    localparam int ADDR_W   = 8;
    localparam int ROM_LAT  = 2;
    localparam int MIX_W    = SAMPLE_W + 3;
    localparam int IDX_W    = $clog2(N_VOICES);

    typedef logic [PHASE_W-1:0]         phase_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [MIX_W-1:0]    mix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mix_state_t;

    // First quarter wave, round(127*sin(2*pi*k/256)) for k = 0..64.
    localparam int QSINE [0:64] = '{
          0,   3,   6,   9,  12,  16,  19,  22,  25,  28,
         31,  34,  37,  40,  43,  46,  49,  51,  54,  57,
         60,  63,  65,  68,  71,  73,  76,  78,  81,  83,
         85,  88,  90,  92,  94,  96,  98, 100, 102, 104,
        106, 107, 109, 111, 112, 113, 115, 116, 117, 118,
        120, 121, 122, 122, 123, 124, 125, 125, 126, 126,
        126, 127, 127, 127, 127
    };

    // Full-wave sample from the quarter table by mirror/negate symmetry.
    function automatic sample_t sine_lookup(input logic [ADDR_W-1:0] i);
        logic [6:0] k;
        logic [6:0] q;
        if (i <= 8'd64)       k = 7'(i);
        else if (i <= 8'd128) k = 7'(8'd128 - i);
        else if (i <= 8'd192) k = 7'(i - 8'd128);
        else                  k = 7'(8'd0 - i);
        q = 7'(QSINE[k]);
        return (i > 8'd128) ? -$signed({1'b0, q}) : $signed({1'b0, q});
    endfunction

    function automatic logic [3:0] popcount(input logic [N_VOICES-1:0] g);
        logic [3:0] c;
        c = 4'd0;
        for (int v = 0; v < N_VOICES; v++) c = c + {3'b000, g[v]};
        return c;
    endfunction

endpackage

// File: rtl/sine_rom.sv
// 256 x 8 signed sine table with registered address and registered data.
// Latency: 2 cycles from addr_in to data_out.
// Backpressure: none; free-running, one lookup accepted every cycle.
module sine_rom
    import synth_pkg::*;
(
    input  logic              clk_in,
    input  logic [ADDR_W-1:0] addr_in,
    output sample_t           data_out
);

    logic [ADDR_W-1:0] addr_q;

    // Two-stage read: capture the address, then the table word.
    always_ff @(posedge clk_in) begin
        addr_q   <= addr_in;
        data_out <= sine_lookup(addr_q);
    end

endmodule

// File: rtl/voice_sine_mixer.sv
// Snapshots 8 voice phases per tick, looks each up in a shared sine ROM, sums the gated voices.
// Latency: mix_valid_out 12 cycles after the edge that samples sample_tick_in.
// Backpressure: none; ticks arriving while a pass is running are dropped and flagged on overrun_out.
module voice_sine_mixer
    import synth_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_tick_in,
    input  logic [N_VOICES-1:0]     gate_in,
    input  phase_t                  phase_in [N_VOICES-1:0],
    output logic signed [MIX_W-1:0] mix_out,
    output logic                    mix_valid_out,
    output logic [3:0]              active_cnt_out,
    output logic                    busy_out,
    output logic                    overrun_out
);

    mix_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [1:0]         drain_q;
    logic [ADDR_W-1:0]  snap_idx_q [N_VOICES-1:0];
    logic [N_VOICES-1:0] snap_gate_q;
    logic               s1_vld_q, s1_gate_q, s2_vld_q, s2_gate_q;
    mix_t               acc_q;
    sample_t            rom_dat;
    logic [ADDR_W-1:0]  rom_addr;
    logic               start;
    logic               unused_phase_lsbs;

    assign start    = sample_tick_in && (state_q == IDLE);
    assign busy_out = (state_q != IDLE);
    assign rom_addr = snap_idx_q[idx_q];

    // Only the top phase bits address the ROM; the fractional part is intentionally dropped.
    always_comb begin
        unused_phase_lsbs = 1'b0;
        for (int v = 0; v < N_VOICES; v++)
            unused_phase_lsbs = unused_phase_lsbs ^ (^phase_in[v][PHASE_W-ADDR_W-1:0]);
    end

    // Next-state: issue all voices, wait for the ROM pipe plus one accumulate, then publish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_tick_in) state_d = ISSUE;
            ISSUE:   if (idx_q == IDX_W'(N_VOICES - 1)) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'(ROM_LAT)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus voice index and drain counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            if (start)                 idx_q <= '0;
            else if (state_q == ISSUE) idx_q <= idx_q + 1'b1;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // Freeze the inputs at the tick so later input changes cannot disturb the pass.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            snap_gate_q <= '0;
            for (int v = 0; v < N_VOICES; v++) snap_idx_q[v] <= '0;
        end else if (start) begin
            snap_gate_q <= gate_in;
            for (int v = 0; v < N_VOICES; v++) snap_idx_q[v] <= phase_in[v][PHASE_W-1 -: ADDR_W];
        end
    end

    sine_rom u_sine_rom (
        .clk_in   (clk_in),
        .addr_in  (rom_addr),
        .data_out (rom_dat)
    );

    // Valid/gate tags travel alongside the ROM's two register stages.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld_q  <= 1'b0;
            s1_gate_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_gate_q <= 1'b0;
        end else begin
            s1_vld_q  <= (state_q == ISSUE);
            s1_gate_q <= snap_gate_q[idx_q];
            s2_vld_q  <= s1_vld_q;
            s2_gate_q <= s1_gate_q;
        end
    end

    // Sum sign-extended samples of gated voices; 11 bits cover 8 x +/-127 without saturation.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_q <= '0;
        end else if (start) begin
            acc_q <= '0;
        end else if (s2_vld_q && s2_gate_q) begin
            acc_q <= acc_q + {{(MIX_W-SAMPLE_W){rom_dat[SAMPLE_W-1]}}, rom_dat};
        end
    end

    // Publish results in DONE and flag ticks that land while a pass is running.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mix_out        <= '0;
            mix_valid_out  <= 1'b0;
            active_cnt_out <= '0;
            overrun_out    <= 1'b0;
        end else begin
            mix_valid_out <= (state_q == DONE);
            overrun_out   <= sample_tick_in && (state_q != IDLE);
            if (state_q == DONE) begin
                mix_out        <= acc_q;
                active_cnt_out <= popcount(snap_gate_q);
            end
        end
    end

endmodule

// File: tb/tb_voice_sine_mixer.sv
// Self-checking bench: directed cases plus a randomized regression against a $sin-based model.
// Latency: checks the 12-cycle tick-to-valid timing on every pass.
// Backpressure: checks overrun flagging and that dropped ticks produce no extra result.
module tb_voice_sine_mixer;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              sample_tick_in;
    logic [7:0]        gate_in;
    logic [31:0]       phase_in [7:0];
    logic signed [10:0] mix_out;
    logic              mix_valid_out;
    logic [3:0]        active_cnt_out;
    logic              busy_out;
    logic              overrun_out;

    int checks = 0;
    int errors = 0;

    voice_sine_mixer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_tick_in (sample_tick_in),
        .gate_in        (gate_in),
        .phase_in       (phase_in),
        .mix_out        (mix_out),
        .mix_valid_out  (mix_valid_out),
        .active_cnt_out (active_cnt_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference sine: rounded 127*sin over a 256-step circle.
    function automatic int ref_sample(input int idx);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * idx / 256.0);
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    function automatic int ref_mix(input logic [7:0] g);
        int s;
        s = 0;
        for (int v = 0; v < 8; v++)
            if (g[v]) s += ref_sample(int'(phase_in[v] >> 24));
        return s;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_all_phase(input logic [31:0] p);
        for (int v = 0; v < 8; v++) phase_in[v] = p;
    endtask

    task automatic rand_phases();
        for (int v = 0; v < 8; v++) phase_in[v] = $urandom;
    endtask

    // One full pass from the current inputs; checks timing and result against the model.
    task automatic run_pass(input string tag);
        int  exp_mix, exp_cnt, n;
        bit  seen;
        exp_mix = ref_mix(gate_in);
        exp_cnt = $countones(gate_in);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        chk_eq({tag, "_busy_hi"}, busy_out, 1);
        chk_eq({tag, "_no_ovr"}, overrun_out, 0);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (mix_valid_out) seen = 1;
        end
        chk_eq({tag, "_latency"}, n, 12);
        chk_eq({tag, "_mix"}, mix_out, exp_mix);
        chk_eq({tag, "_cnt"}, active_cnt_out, exp_cnt);
        step();
        chk_eq({tag, "_vld_1cyc"}, mix_valid_out, 0);
        chk_eq({tag, "_busy_lo"}, busy_out, 0);
    endtask

    initial begin
        int ov, vcnt, vpos, extra;

        rst_in = 1'b1;
        sample_tick_in = 1'b0;
        gate_in = 8'h00;
        set_all_phase(32'h0);
        repeat (3) step();
        chk_eq("rst_mix", mix_out, 0);
        chk_eq("rst_vld", mix_valid_out, 0);
        chk_eq("rst_cnt", active_cnt_out, 0);
        chk_eq("rst_busy", busy_out, 0);
        chk_eq("rst_ovr", overrun_out, 0);
        rst_in = 1'b0;
        repeat (2) step();

        // Directed cases with hand-derived results.
        gate_in = 8'hFF; set_all_phase(32'h0000_0000);
        run_pass("zero"); chk_eq("zero_const", mix_out, 0);
        gate_in = 8'h03; rand_phases(); phase_in[0] = 32'h4000_0000; phase_in[1] = 32'h4000_0000;
        run_pass("quarter"); chk_eq("quarter_const", mix_out, 254); chk_eq("quarter_cnt", active_cnt_out, 2);
        phase_in[0] = 32'hC000_0000; phase_in[1] = 32'hC000_0000;
        run_pass("threeq"); chk_eq("threeq_const", mix_out, -254);
        gate_in = 8'hFF; set_all_phase(32'h4000_0000);
        run_pass("maxpos"); chk_eq("maxpos_const", mix_out, 1016);
        set_all_phase(32'hC0FF_FFFF);
        run_pass("maxneg"); chk_eq("maxneg_const", mix_out, -1016);
        gate_in = 8'h00; rand_phases();
        run_pass("nogate"); chk_eq("nogate_const", mix_out, 0); chk_eq("nogate_cnt", active_cnt_out, 0);

        // Snapshot isolation and overrun: inputs change at cycle 3, extra tick at cycle 5.
        gate_in = 8'hFF; set_all_phase(32'h4000_0000);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        ov = 0; vcnt = 0; vpos = -1;
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) begin
                gate_in = 8'h5A;
                rand_phases();
            end
            sample_tick_in = (n == 5);
            step();
            if (overrun_out) ov++;
            if (n == 5) chk_eq("snap_ovr_at5", overrun_out, 1);
            if (mix_valid_out) begin
                vcnt++;
                vpos = n;
            end
        end
        sample_tick_in = 1'b0;
        chk_eq("snap_vpos", vpos, 12);
        chk_eq("snap_vcnt", vcnt, 1);
        chk_eq("snap_ovr_cnt", ov, 1);
        chk_eq("snap_mix", mix_out, 1016);
        chk_eq("snap_cnt", active_cnt_out, 8);
        run_pass("tick13");

        // Reset in the middle of a pass.
        gate_in = 8'hFF; set_all_phase(32'h4000_0000);
        run_pass("pre_rst");
        gate_in = 8'hA5; rand_phases();
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        repeat (5) step();
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk_eq("mrst_mix", mix_out, 0);
        chk_eq("mrst_vld", mix_valid_out, 0);
        chk_eq("mrst_cnt", active_cnt_out, 0);
        chk_eq("mrst_busy", busy_out, 0);
        chk_eq("mrst_ovr", overrun_out, 0);
        step();
        rst_in = 1'b0;
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (mix_valid_out) extra++;
        end
        chk_eq("mrst_no_vld", extra, 0);
        run_pass("post_rst");

        // Randomized regression, ticks spaced 16+ cycles apart.
        for (int t = 0; t < 1000; t++) begin
            gate_in = 8'($urandom);
            rand_phases();
            run_pass("rand");
            repeat ($urandom_range(2, 6)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
